// File: rtl/video_timing_if.sv
// Pixel FIFO read port plus raster video output bundle.
// master = timing source, slave = downstream ISP / FIFO side.
interface video_timing_if;
  logic       en;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;
  logic       vid_de;
  logic       vid_hsync;
  logic       vid_vsync;
  logic [7:0] vid_data;
  logic       frame_start;
  logic       underflow;
  logic       underflow_clr;

  modport master (
    input  en,
    input  fifo_empty,
    input  fifo_dout,
    input  underflow_clr,
    output fifo_rd_en,
    output vid_de,
    output vid_hsync,
    output vid_vsync,
    output vid_data,
    output frame_start,
    output underflow
  );

  modport slave (
    output en,
    output fifo_empty,
    output fifo_dout,
    output underflow_clr,
    input  fifo_rd_en,
    input  vid_de,
    input  vid_hsync,
    input  vid_vsync,
    input  vid_data,
    input  frame_start,
    input  underflow
  );
endinterface

// File: rtl/video_timing_source.sv
// Raster video timing source fed from a pixel FIFO.
// Stage 0 = counters/FSM, stage 1 = registered video outputs.
module video_timing_source #(
  parameter int   H_DISP   = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_DISP   = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  video_timing_if.master vif
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  typedef logic [HW-1:0] h_t;
  typedef logic [VW-1:0] v_t;

  localparam h_t H_DE   = h_t'(H_DISP);
  localparam h_t H_HS0  = h_t'(H_DISP + H_FP);
  localparam h_t H_HS1  = h_t'(H_DISP + H_FP + H_SYNC);
  localparam h_t H_LAST = h_t'(H_TOTAL - 1);
  localparam v_t V_DE   = v_t'(V_DISP);
  localparam v_t V_VS0  = v_t'(V_DISP + V_FP);
  localparam v_t V_VS1  = v_t'(V_DISP + V_FP + V_SYNC);
  localparam v_t V_LAST = v_t'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t r_state;
  h_t     r_h;
  v_t     r_v;
  logic   r_rd;
  logic   r_de;
  logic   r_hs;
  logic   r_vs;
  logic   r_fs;
  logic   r_uf;

  logic w_act;
  logic w_h_last;
  logic w_wrap;
  logic w_de_pre;
  logic w_hs_pre;
  logic w_vs_pre;
  logic w_fs_pre;
  logic w_rd;

  assign w_act    = (r_state != S_IDLE);
  assign w_h_last = (r_h == H_LAST);
  assign w_wrap   = w_h_last && (r_v == V_LAST);
  assign w_de_pre = w_act && (r_h < H_DE) && (r_v < V_DE);
  assign w_hs_pre = w_act && (r_h >= H_HS0) && (r_h < H_HS1);
  assign w_vs_pre = w_act && (r_v >= V_VS0) && (r_v < V_VS1);
  assign w_fs_pre = w_act && (r_h == '0) && (r_v == '0);
  assign w_rd     = w_de_pre && !vif.fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_h     <= '0;
      r_v     <= '0;
      r_rd    <= 1'b0;
      r_de    <= 1'b0;
      r_hs    <= ~SYNC_POL;
      r_vs    <= ~SYNC_POL;
      r_fs    <= 1'b0;
      r_uf    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (vif.en) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_wrap)
            r_state <= vif.en ? S_RUN : S_IDLE;
          else if (!vif.en)
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_wrap)
            r_state <= vif.en ? S_RUN : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // counters free-run while a frame is being emitted, held at 0 otherwise
      if (!w_act) begin
        r_h <= '0;
        r_v <= '0;
      end else if (w_h_last) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end

      r_rd <= w_rd;
      r_de <= w_de_pre;
      r_hs <= w_hs_pre ? SYNC_POL : ~SYNC_POL;
      r_vs <= w_vs_pre ? SYNC_POL : ~SYNC_POL;
      r_fs <= w_fs_pre;

      // a new underflow beats a simultaneous clear
      if (w_de_pre && vif.fifo_empty)
        r_uf <= 1'b1;
      else if (vif.underflow_clr)
        r_uf <= 1'b0;
    end
  end

  assign vif.fifo_rd_en  = w_rd;
  assign vif.vid_de      = r_de;
  assign vif.vid_hsync   = r_hs;
  assign vif.vid_vsync   = r_vs;
  assign vif.vid_data    = r_rd ? vif.fifo_dout : 8'h00;
  assign vif.frame_start = r_fs;
  assign vif.underflow   = r_uf;

endmodule

// File: tb/tb_video_timing_source.sv
// Bench for video_timing_source: 16x8 raster, active-low and
// active-high sync instances sharing one FIFO model.
module tb_video_timing_source;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       fifo_empty;
  logic       uf_clr;
  logic       exp_zero;
  logic [7:0] fifo_dout;
  logic [7:0] gen;
  logic [7:0] exp_q[$];

  int tests;
  int fails;

  typedef struct {
    int h;
    int v;
    bit de;
    bit hs;
    bit vs;
  } vec_t;

  vec_t tbl[16];

  video_timing_if vif0();
  video_timing_if vif1();

  assign vif0.en            = en;
  assign vif0.fifo_empty    = fifo_empty;
  assign vif0.fifo_dout     = fifo_dout;
  assign vif0.underflow_clr = uf_clr;
  assign vif1.en            = en;
  assign vif1.fifo_empty    = fifo_empty;
  assign vif1.fifo_dout     = fifo_dout;
  assign vif1.underflow_clr = uf_clr;

  video_timing_source #(
    .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0)
  ) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (vif0)
  );

  video_timing_source #(
    .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (vif1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // FIFO model with 1-clk read latency; every read or starved
  // pixel pushes the value expected on the output
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen       <= 8'h01;
      fifo_dout <= 8'h00;
      exp_q.delete();
    end else if (vif0.fifo_rd_en) begin
      fifo_dout <= gen;
      exp_q.push_back(gen);
      gen       <= gen + 8'h01;
    end else if (fifo_empty && exp_zero) begin
      exp_q.push_back(8'h00);
    end
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n) begin
      if (vif0.vid_de) begin
        if (exp_q.size() == 0) begin
          chk("sb_underrun", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data0", 32'(vif0.vid_data), 32'(e));
          chk("sb_data1", 32'(vif1.vid_data), 32'(e));
        end
      end else begin
        chk("blank_data", 32'(vif0.vid_data), 32'd0);
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_de"},  32'(vif0.vid_de), 0);
    chk({nm, "_dat"}, 32'(vif0.vid_data), 0);
    chk({nm, "_fs"},  32'(vif0.frame_start), 0);
    chk({nm, "_uf"},  32'(vif0.underflow), 0);
    chk({nm, "_rd"},  32'(vif0.fifo_rd_en), 0);
    chk({nm, "_hs0"}, 32'(vif0.vid_hsync), 1);
    chk({nm, "_vs0"}, 32'(vif0.vid_vsync), 1);
    chk({nm, "_hs1"}, 32'(vif1.vid_hsync), 0);
    chk({nm, "_vs1"}, 32'(vif1.vid_vsync), 0);
  endtask

  // leaves the bench at a negedge with the DUTs idle and en low
  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    en         = 1'b0;
    fifo_empty = 1'b0;
    uf_clr     = 1'b0;
    exp_zero   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int n_de;
    int n_fs;
    int n_bad;
    tests = 0;
    fails = 0;

    tbl[0]  = '{0,  0, 1, 0, 0};
    tbl[1]  = '{7,  0, 1, 0, 0};
    tbl[2]  = '{8,  0, 0, 0, 0};
    tbl[3]  = '{9,  0, 0, 0, 0};
    tbl[4]  = '{10, 0, 0, 1, 0};
    tbl[5]  = '{12, 0, 0, 1, 0};
    tbl[6]  = '{13, 0, 0, 0, 0};
    tbl[7]  = '{15, 0, 0, 0, 0};
    tbl[8]  = '{3,  3, 1, 0, 0};
    tbl[9]  = '{0,  4, 0, 0, 0};
    tbl[10] = '{11, 4, 0, 1, 0};
    tbl[11] = '{0,  5, 0, 0, 1};
    tbl[12] = '{15, 6, 0, 0, 1};
    tbl[13] = '{11, 6, 0, 1, 1};
    tbl[14] = '{0,  7, 0, 0, 0};
    tbl[15] = '{15, 7, 0, 0, 0};

    rst_n      = 1'b1;
    en         = 1'b0;
    fifo_empty = 1'b0;
    uf_clr     = 1'b0;
    exp_zero   = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_reset("por");
    wait_n(2);
    rst_n = 1'b1;
    @(negedge clk);

    // timing and data: output position t appears at negedge E+2+t
    en = 1'b1;
    @(negedge clk);
    n_de = 0;
    n_fs = 0;
    for (int t = 0; t < 128; t++) begin
      @(negedge clk);
      if (vif0.vid_de) n_de++;
      if (vif0.frame_start) n_fs++;
      if (t == 0)  chk("pix_first", 32'(vif0.vid_data), 32'h01);
      if (t == 55) chk("pix_last", 32'(vif0.vid_data), 32'h20);
      for (int k = 0; k < 16; k++) begin
        if (tbl[k].h == t % 16 && tbl[k].v == t / 16) begin
          chk("tbl_de0", 32'(vif0.vid_de), 32'(tbl[k].de));
          chk("tbl_de1", 32'(vif1.vid_de), 32'(tbl[k].de));
          chk("tbl_hs0", 32'(vif0.vid_hsync), 32'(!tbl[k].hs));
          chk("tbl_vs0", 32'(vif0.vid_vsync), 32'(!tbl[k].vs));
          chk("tbl_hs1", 32'(vif1.vid_hsync), 32'(tbl[k].hs));
          chk("tbl_vs1", 32'(vif1.vid_vsync), 32'(tbl[k].vs));
        end
      end
    end
    chk("de_per_frame", n_de, 32);
    chk("fs_per_frame", n_fs, 1);
    @(negedge clk);
    chk("fs_period", 32'(vif0.frame_start), 1);
    chk("pix_next", 32'(vif0.vid_data), 32'h21);

    // underflow on pixel (3,1), then clear, then set+clr together
    do_reset();
    en = 1'b1;
    wait_n(20);
    fifo_empty = 1'b1;
    exp_zero   = 1'b1;
    wait_n(1);
    fifo_empty = 1'b0;
    exp_zero   = 1'b0;
    chk("uf_pix", 32'(vif0.vid_data), 0);
    chk("uf_set", 32'(vif0.underflow), 1);
    wait_n(5);
    chk("uf_hold", 32'(vif0.underflow), 1);
    uf_clr = 1'b1;
    wait_n(1);
    uf_clr = 1'b0;
    chk("uf_clr0", 32'(vif0.underflow), 0);
    chk("uf_clr1", 32'(vif1.underflow), 0);
    wait_n(102);
    chk("uf_fs_early", 32'(vif0.frame_start), 0);
    wait_n(1);
    chk("uf_fs_period", 32'(vif0.frame_start), 1);
    wait_n(18);
    fifo_empty = 1'b1;
    exp_zero   = 1'b1;
    uf_clr     = 1'b1;
    wait_n(1);
    fifo_empty = 1'b0;
    exp_zero   = 1'b0;
    uf_clr     = 1'b0;
    chk("uf_setclr0", 32'(vif0.underflow), 1);
    chk("uf_setclr1", 32'(vif1.underflow), 1);

    // stop mid-frame at (5,2): frame completes, then idle
    do_reset();
    en = 1'b1;
    n_de  = 0;
    n_bad = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 38) en = 1'b0;
      if (k >= 2 && k <= 129 && vif0.vid_de) n_de++;
      if (k >= 130 && (vif0.vid_de || vif0.frame_start ||
          vif0.fifo_rd_en || !vif0.vid_hsync || !vif0.vid_vsync ||
          vif1.vid_hsync || vif1.vid_vsync))
        n_bad++;
    end
    chk("stop_de", n_de, 32);
    chk("stop_idle", n_bad, 0);
    en = 1'b1;
    wait_n(1);
    chk("restart_fs_early", 32'(vif0.frame_start), 0);
    wait_n(1);
    chk("restart_fs", 32'(vif0.frame_start), 1);

    // en dropped then re-asserted within the same frame
    do_reset();
    en = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk);
      if (k == 38) en = 1'b0;
      if (k == 60) en = 1'b1;
      if (k == 129) chk("drain_fs_early", 32'(vif0.frame_start), 0);
      if (k == 130) chk("drain_rerun", 32'(vif0.frame_start), 1);
    end

    // async reset while de is high at (4,1)
    do_reset();
    en = 1'b1;
    wait_n(22);
    chk("pre_rst_de", 32'(vif0.vid_de), 1);
    chk("pre_rst_rd", 32'(vif0.fifo_rd_en), 1);
    #2 rst_n = 1'b0;
    en = 1'b0;
    #1 chk_reset("async");
    @(negedge clk);
    rst_n = 1'b1;
    n_bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (vif0.vid_de || vif0.frame_start || vif0.fifo_rd_en) n_bad++;
    end
    chk("post_rst_idle", n_bad, 0);
    en = 1'b1;
    wait_n(2);
    chk("post_rst_fs", 32'(vif0.frame_start), 1);
    chk("post_rst_de", 32'(vif0.vid_de), 1);

    wait_n(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
